// File: rtl/vga_console_ctrl_pkg.sv
// Shared constants, state encodings and address helpers for the VGA text console write sequencer.
package vga_console_ctrl_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned PHYS_W = ROW_W + 1;

    localparam logic [7:0] FILL_CHAR = 8'h20;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_FF     = 8'h0C;
    localparam logic [7:0] CH_CR     = 8'h0D;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITE     = 2'd1;
    localparam logic [1:0] CLEAR_ROW = 2'd2;
    localparam logic [1:0] CLEAR_ALL = 2'd3;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } vram_wr_t;

    // First cell of the physical row holding logical row `row`; wraps without a modulo operator.
    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row,
                                                   input logic [ROW_W-1:0] scroll);
        logic [PHYS_W-1:0] phys;
        phys = {1'b0, row} + {1'b0, scroll};
        if (phys >= PHYS_W'(ROWS)) phys = phys - PHYS_W'(ROWS);
        return ADDR_W'(phys) * ADDR_W'(COLS);
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] row,
                                                    input logic [ROW_W-1:0] scroll);
        return row_base(row, scroll) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/vram_fill_engine.sv
// Issues `len` consecutive fill writes starting at `base`, then pulses done for one cycle.
module vram_fill_engine
    import vga_console_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              done
);

    logic [ADDR_W-1:0] remaining;

    // remaining counts writes still owed after the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_we   <= 1'b0;
            fill_addr <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                fill_we   <= 1'b1;
                fill_addr <= base;
                remaining <= len - ADDR_W'(1);
            end else if (fill_we) begin
                if (remaining == '0) begin
                    fill_we <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    fill_addr <= fill_addr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vga_console_ctrl.sv
// Byte-stream console: decodes characters/control codes into VRAM writes, tracks the cursor
// and scrolls by clearing one row and advancing scroll_row instead of copying VRAM.
module vga_console_ctrl
    import vga_console_ctrl_pkg::*;
(
    input  logic              clk_25mhz,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [7:0]        vram_wdata,
    output logic [ROW_W-1:0]  scroll_row,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  scroll_d;
    vram_wr_t          wr_q, wr_d;
    logic              newline;

    logic              fill_start_c;
    logic [ADDR_W-1:0] fill_base_c;
    logic [ADDR_W-1:0] fill_len_c;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_done;

    vram_fill_engine u_fill (
        .clk       (clk_25mhz),
        .rst_n     (reset_n),
        .start     (fill_start_c),
        .base      (fill_base_c),
        .len       (fill_len_c),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .done      (fill_done)
    );

    assign vram_we    = wr_q.we;
    assign vram_waddr = wr_q.addr;
    assign vram_wdata = wr_q.data;

    // Fill engine starts on the accept cycle so a scroll costs exactly one extra slot plus COLS writes.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        scroll_d     = scroll_row;
        wr_d         = '{we: 1'b0, addr: wr_q.addr, data: wr_q.data};
        newline      = 1'b0;
        fill_start_c = 1'b0;
        fill_base_c  = '0;
        fill_len_c   = '0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_d    = '{we: 1'b1, addr: cursor_addr, data: in_data};
                        state_d = WRITE;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d   = '0;
                            newline = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        case (in_data)
                            CH_LF: begin
                                col_d   = '0;
                                newline = 1'b1;
                                state_d = WRITE;
                            end
                            CH_CR: col_d = '0;
                            CH_BS: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - COL_W'(1);
                                    wr_d    = '{we: 1'b1, addr: cursor_addr - ADDR_W'(1), data: FILL_CHAR};
                                    state_d = WRITE;
                                end
                            end
                            CH_FF: begin
                                fill_start_c = 1'b1;
                                fill_len_c   = ADDR_W'(CELLS);
                                state_d      = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end

                    // Bottom row: the oldest physical row (at scroll_row) becomes the new bottom line.
                    if (newline) begin
                        if (row_q < ROW_W'(ROWS - 1)) begin
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            fill_start_c = 1'b1;
                            fill_base_c  = row_base('0, scroll_row);
                            fill_len_c   = ADDR_W'(COLS);
                            state_d      = CLEAR_ROW;
                        end
                    end
                end
            end

            WRITE: state_d = IDLE;

            CLEAR_ROW, CLEAR_ALL: begin
                wr_d = '{we: fill_we, addr: fill_addr, data: FILL_CHAR};
                if (fill_done) begin
                    state_d = IDLE;
                    if (state_q == CLEAR_ROW) begin
                        scroll_d = (scroll_row == ROW_W'(ROWS - 1)) ? '0 : scroll_row + ROW_W'(1);
                    end else begin
                        col_d    = '0;
                        row_d    = '0;
                        scroll_d = '0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            scroll_row  <= '0;
            wr_q        <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            cursor_addr <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            scroll_row  <= scroll_d;
            wr_q        <= wr_d;
            in_ready    <= (state_d == IDLE);
            busy        <= (state_d != IDLE);
            cursor_addr <= cell_addr(col_d, row_d, scroll_d);
        end
    end

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed self-checking bench for vga_console_ctrl: writes, row wrap, scrolling, backspace, clears, reset abort.
module tb_vga_console_ctrl;

    logic        clk_25mhz = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  in_data   = 8'h00;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic        vram_we;
    logic [11:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic [4:0]  scroll_row;
    logic [11:0] cursor_addr;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int wr_count, first_addr, last_addr, last_data, non_fill, bad_addr;

    vga_console_ctrl dut (
        .clk_25mhz   (clk_25mhz),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .vram_we     (vram_we),
        .vram_waddr  (vram_waddr),
        .vram_wdata  (vram_wdata),
        .scroll_row  (scroll_row),
        .cursor_addr (cursor_addr),
        .busy        (busy)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    // Write log, sampled on the falling edge.
    always @(negedge clk_25mhz) begin
        if (reset_n && vram_we) begin
            if (wr_count == 0) first_addr = int'(vram_waddr);
            last_addr = int'(vram_waddr);
            last_data = int'(vram_wdata);
            if (vram_wdata != 8'h20) non_fill++;
            if (vram_waddr >= 12'd2400) bad_addr++;
            wr_count++;
        end
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation still running at cycle 60000, want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_25mhz);
        #1;
    endtask

    task automatic clr_log();
        wr_count = 0; first_addr = -1; last_addr = -1; last_data = -1; non_fill = 0; bad_addr = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset_n  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        clr_log();
    endtask

    // Returns at the sample point right after the accepting clock edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 5000) begin tick(); n++; end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
        end
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!in_ready && cyc < 5000) begin tick(); cyc++; end
    endtask

    task automatic send_idle(input logic [7:0] b);
        int c;
        send_byte(b);
        wait_idle(c);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (vram_we !== 1'b0) $display("FAIL rst_we: got %0b want 0", vram_we); else n_pass++;
        n_total++; if (vram_waddr !== 12'd0) $display("FAIL rst_waddr: got %0d want 0", vram_waddr); else n_pass++;
        n_total++; if (vram_wdata !== 8'h00) $display("FAIL rst_wdata: got %0h want 0", vram_wdata); else n_pass++;
        n_total++; if (scroll_row !== 5'd0) $display("FAIL rst_scroll: got %0d want 0", scroll_row); else n_pass++;
        n_total++; if (cursor_addr !== 12'd0) $display("FAIL rst_cursor: got %0d want 0", cursor_addr); else n_pass++;
    endtask

    task automatic test_single_write();
        int cyc;
        do_reset();
        send_byte(8'h41);
        n_total++; if (vram_we !== 1'b1) $display("FAIL a_we: got %0b want 1", vram_we); else n_pass++;
        n_total++; if (vram_waddr !== 12'd0) $display("FAIL a_waddr: got %0d want 0", vram_waddr); else n_pass++;
        n_total++; if (vram_wdata !== 8'h41) $display("FAIL a_wdata: got %0h want 41", vram_wdata); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL a_ready_low: got %0b want 0", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL a_busy: got %0b want 1", busy); else n_pass++;
        wait_idle(cyc);
        n_total++; if (cyc != 1) $display("FAIL a_latency: got %0d want 1", cyc); else n_pass++;
        n_total++; if (vram_we !== 1'b0) $display("FAIL a_we_drop: got %0b want 0", vram_we); else n_pass++;
        n_total++; if (cursor_addr !== 12'd1) $display("FAIL a_cursor: got %0d want 1", cursor_addr); else n_pass++;
        n_total++; if (wr_count != 1) $display("FAIL a_count: got %0d want 1", wr_count); else n_pass++;
    endtask

    task automatic test_row_wrap();
        do_reset();
        for (int i = 0; i < 80; i++) send_idle(8'h42);
        n_total++; if (wr_count != 80) $display("FAIL wrap_count: got %0d want 80", wr_count); else n_pass++;
        n_total++; if (last_addr != 79) $display("FAIL wrap_last: got %0d want 79", last_addr); else n_pass++;
        n_total++; if (last_data != 8'h42) $display("FAIL wrap_data: got %0h want 42", last_data); else n_pass++;
        n_total++; if (cursor_addr !== 12'd80) $display("FAIL wrap_cursor: got %0d want 80", cursor_addr); else n_pass++;
        n_total++; if (scroll_row !== 5'd0) $display("FAIL wrap_scroll: got %0d want 0", scroll_row); else n_pass++;
    endtask

    task automatic test_scroll();
        int cyc;
        do_reset();
        for (int i = 0; i < 29; i++) send_idle(8'h0A);
        n_total++; if (cursor_addr !== 12'd2320) $display("FAIL lf_cursor: got %0d want 2320", cursor_addr); else n_pass++;
        n_total++; if (wr_count != 0) $display("FAIL lf_nowrite: got %0d want 0", wr_count); else n_pass++;
        send_byte(8'h0A);
        wait_idle(cyc);
        n_total++; if (cyc != 81) $display("FAIL scr_latency: got %0d want 81", cyc); else n_pass++;
        n_total++; if (wr_count != 80) $display("FAIL scr_count: got %0d want 80", wr_count); else n_pass++;
        n_total++; if (first_addr != 0) $display("FAIL scr_first: got %0d want 0", first_addr); else n_pass++;
        n_total++; if (last_addr != 79) $display("FAIL scr_last: got %0d want 79", last_addr); else n_pass++;
        n_total++; if (non_fill != 0) $display("FAIL scr_fill: got %0d want 0", non_fill); else n_pass++;
        n_total++; if (scroll_row !== 5'd1) $display("FAIL scr_row: got %0d want 1", scroll_row); else n_pass++;
        n_total++; if (cursor_addr !== 12'd0) $display("FAIL scr_cursor: got %0d want 0", cursor_addr); else n_pass++;
        send_byte(8'h43);
        n_total++; if (vram_waddr !== 12'd0) $display("FAIL c_waddr: got %0d want 0", vram_waddr); else n_pass++;
        n_total++; if (vram_wdata !== 8'h43) $display("FAIL c_wdata: got %0h want 43", vram_wdata); else n_pass++;
        wait_idle(cyc);
    endtask

    // Continues from test_scroll: row 29, col 1, scroll_row 1.
    task automatic test_wraparound();
        int cyc;
        send_idle(8'h0D);
        for (int i = 0; i < 28; i++) send_idle(8'h0A);
        n_total++; if (scroll_row !== 5'd29) $display("FAIL wa_scroll: got %0d want 29", scroll_row); else n_pass++;
        n_total++; if (cursor_addr !== 12'd2240) $display("FAIL wa_cursor: got %0d want 2240", cursor_addr); else n_pass++;
        for (int i = 0; i < 5; i++) send_idle(8'h61);
        send_byte(8'h44);
        n_total++; if (vram_waddr !== 12'd2245) $display("FAIL wa_waddr: got %0d want 2245", vram_waddr); else n_pass++;
        wait_idle(cyc);
        send_idle(8'h0D);
        clr_log();
        send_byte(8'h0A);
        wait_idle(cyc);
        n_total++; if (first_addr != 2320) $display("FAIL wa_first: got %0d want 2320", first_addr); else n_pass++;
        n_total++; if (last_addr != 2399) $display("FAIL wa_last: got %0d want 2399", last_addr); else n_pass++;
        n_total++; if (wr_count != 80) $display("FAIL wa_count: got %0d want 80", wr_count); else n_pass++;
        n_total++; if (scroll_row !== 5'd0) $display("FAIL wa_scroll_wrap: got %0d want 0", scroll_row); else n_pass++;
        n_total++; if (cursor_addr !== 12'd2320) $display("FAIL wa_cursor2: got %0d want 2320", cursor_addr); else n_pass++;
    endtask

    task automatic test_backspace();
        int cyc;
        do_reset();
        for (int i = 0; i < 3; i++) send_idle(8'h61);
        send_byte(8'h08);
        n_total++; if (vram_we !== 1'b1) $display("FAIL bs_we: got %0b want 1", vram_we); else n_pass++;
        n_total++; if (vram_waddr !== 12'd2) $display("FAIL bs_waddr: got %0d want 2", vram_waddr); else n_pass++;
        n_total++; if (vram_wdata !== 8'h20) $display("FAIL bs_wdata: got %0h want 20", vram_wdata); else n_pass++;
        wait_idle(cyc);
        n_total++; if (cursor_addr !== 12'd2) $display("FAIL bs_cursor: got %0d want 2", cursor_addr); else n_pass++;
        send_idle(8'h08);
        send_idle(8'h08);
        clr_log();
        send_byte(8'h08);
        n_total++; if (vram_we !== 1'b0) $display("FAIL bs0_we: got %0b want 0", vram_we); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bs0_ready: got %0b want 1", in_ready); else n_pass++;
        n_total++; if (cursor_addr !== 12'd0) $display("FAIL bs0_cursor: got %0d want 0", cursor_addr); else n_pass++;
        send_idle(8'h61);
        clr_log();
        send_idle(8'h01);
        send_idle(8'h7F);
        n_total++; if (wr_count != 0) $display("FAIL drop_write: got %0d want 0", wr_count); else n_pass++;
        n_total++; if (cursor_addr !== 12'd1) $display("FAIL drop_cursor: got %0d want 1", cursor_addr); else n_pass++;
        send_idle(8'h0D);
        n_total++; if (cursor_addr !== 12'd0) $display("FAIL cr_cursor: got %0d want 0", cursor_addr); else n_pass++;
        n_total++; if (wr_count != 0) $display("FAIL cr_write: got %0d want 0", wr_count); else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        int cyc;
        do_reset();
        send_idle(8'h51);
        send_idle(8'h0A);
        clr_log();
        send_byte(8'h0C);
        while (wr_count < 1000 && n < 2000) begin tick(); n++; end
        n_total++; if (wr_count != 1000) $display("FAIL ff_reach1000: got %0d want 1000", wr_count); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++; if (vram_we !== 1'b0) $display("FAIL abort_we: got %0b want 0", vram_we); else n_pass++;
        n_total++; if (vram_waddr !== 12'd0) $display("FAIL abort_waddr: got %0d want 0", vram_waddr); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL abort_ready: got %0b want 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (cursor_addr !== 12'd0) $display("FAIL abort_cursor: got %0d want 0", cursor_addr); else n_pass++;
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        n_total++; if (wr_count != 1000) $display("FAIL abort_stopped: got %0d want 1000", wr_count); else n_pass++;
        clr_log();
        send_byte(8'h0C);
        wait_idle(cyc);
        n_total++; if (wr_count != 2400) $display("FAIL ff_count: got %0d want 2400", wr_count); else n_pass++;
        n_total++; if (first_addr != 0) $display("FAIL ff_first: got %0d want 0", first_addr); else n_pass++;
        n_total++; if (last_addr != 2399) $display("FAIL ff_last: got %0d want 2399", last_addr); else n_pass++;
        n_total++; if (non_fill != 0 || bad_addr != 0) $display("FAIL ff_data: got %0d/%0d want 0/0", non_fill, bad_addr); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ff_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (scroll_row !== 5'd0) $display("FAIL ff_scroll: got %0d want 0", scroll_row); else n_pass++;
        n_total++; if (cursor_addr !== 12'd0) $display("FAIL ff_cursor: got %0d want 0", cursor_addr); else n_pass++;
    endtask

    initial begin
        clr_log();
        test_reset();
        test_single_write();
        test_row_wrap();
        test_scroll();
        test_wraparound();
        test_backspace();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
